sdram_work_fsm: RTL and testbench



---
 rtl/sdram_para.sv | 42 ++++
 rtl/sdram_ref_timer.sv | 47 ++++
 rtl/sdram_work_fsm.sv | 190 +++++++++++++++++++
 tb/tb_sdram_work_fsm.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_para.sv
// Shared definitions for the SDRAM work sequencer: state encodings, default
// timing constants and the burst-length clamp.
package sdram_para;

    typedef enum logic [3:0] {
        W_IDLE   = 4'd0,
        W_ACTIVE = 4'd1,
        W_TRCD   = 4'd2,
        W_READ   = 4'd3,
        W_CL     = 4'd4,
        W_RD     = 4'd5,
        W_WRITE  = 4'd6,
        W_WD     = 4'd7,
        W_TWR    = 4'd8,
        W_PRE    = 4'd9,
        W_TRP    = 4'd10,
        W_AR     = 4'd11,
        W_TRFC   = 4'd12
    } work_state_t;

    localparam int DEF_TRCD       = 2;
    localparam int DEF_TCL        = 3;
    localparam int DEF_TWR        = 2;
    localparam int DEF_TRP        = 2;
    localparam int DEF_TRFC       = 7;
    localparam int DEF_REF_PERIOD = 781;
    localparam int MAX_BURST      = 512;

    // A zero-length request still moves one word; anything longer than a page is cut to a page.
    function automatic logic [9:0] clamp_burst(input logic [9:0] len);
        logic [9:0] res;
        if (len == 10'd0) begin
            res = 10'd1;
        end else if (len > 10'(MAX_BURST)) begin
            res = 10'(MAX_BURST);
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// Auto-refresh interval timer: raises a sticky pending flag every REF_PERIOD
// cycles of init_done and drops it when the sequencer starts the refresh.
module sdram_ref_timer
    import sdram_para::*;
#(
    parameter int REF_PERIOD = DEF_REF_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_pend
);

    localparam int            TW     = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
    localparam logic [TW-1:0] L_LAST = TW'(REF_PERIOD - 1);

    logic [TW-1:0] r_tmr;
    logic          r_pend;

    // Interval counter and pending flag; a new expiry wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmr  <= '0;
            r_pend <= 1'b0;
        end else begin
            if (!i_en) begin
                r_tmr <= '0;
            end else if (r_tmr == L_LAST) begin
                r_tmr <= '0;
            end else begin
                r_tmr <= r_tmr + TW'(1);
            end

            if (i_en && (r_tmr == L_LAST)) begin
                r_pend <= 1'b1;
            end else if (i_clr) begin
                r_pend <= 1'b0;
            end else begin
                r_pend <= r_pend;
            end
        end
    end

    assign o_pend = r_pend;

endmodule

// File: rtl/sdram_work_fsm.sv
// SDRAM work sequencer: arbitrates refresh / write / read after init and drives
// work_state + cnt_clk for the data-path stage. SDRAM_AUTO_PRECHARGE_EN drops W_PRE.
module sdram_work_fsm
    import sdram_para::*;
#(
    parameter int TRCD       = DEF_TRCD,
    parameter int TCL        = DEF_TCL,
    parameter int TWR        = DEF_TWR,
    parameter int TRP        = DEF_TRP,
    parameter int TRFC       = DEF_TRFC,
    parameter int REF_PERIOD = DEF_REF_PERIOD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_done,
    input  logic       wr_req,
    input  logic       rd_req,
    input  logic [9:0] wr_burst,
    input  logic [9:0] rd_burst,
    output logic [3:0] work_state,
    output logic [9:0] cnt_clk,
    output logic       wr_start,
    output logic       rd_start,
    output logic       wr_ack,
    output logic       rd_valid,
    output logic       burst_done
);

    localparam logic [9:0] L_TRCD_END = 10'(TRCD - 2);
    localparam logic [9:0] L_CL_END   = 10'(TCL - 2);
    localparam logic [9:0] L_TWR_END  = 10'(TWR - 1);
    localparam logic [9:0] L_TRP_END  = 10'(TRP - 1);
    localparam logic [9:0] L_TRFC_END = 10'(TRFC - 1);

`ifdef SDRAM_AUTO_PRECHARGE_EN
    localparam work_state_t L_AFTER_XFER = W_TRP;
`else
    localparam work_state_t L_AFTER_XFER = W_PRE;
`endif

    work_state_t r_state;
    logic [9:0]  r_cnt;
    logic [9:0]  r_burst;
    logic        r_is_wr;
    logic        r_wr_start;
    logic        r_rd_start;
    logic        r_rd_valid;
    logic        r_burst_done;

    logic        w_ref_pend;
    logic        w_ref_clr;
    logic [9:0]  w_cnt_inc;

    assign w_ref_clr = (r_state == W_IDLE) && init_done && w_ref_pend;
    assign w_cnt_inc = (r_cnt == 10'd1023) ? r_cnt : (r_cnt + 10'd1);

    sdram_ref_timer #(
        .REF_PERIOD (REF_PERIOD)
    ) u_ref_timer (
        .clk    (clk),
        .rst    (rst),
        .i_en   (init_done),
        .i_clr  (w_ref_clr),
        .o_pend (w_ref_pend)
    );

    // Main sequencer: every transition reloads cnt_clk to 0, otherwise it saturates upward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= W_IDLE;
            r_cnt        <= 10'd0;
            r_burst      <= 10'd1;
            r_is_wr      <= 1'b0;
            r_wr_start   <= 1'b0;
            r_rd_start   <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_burst_done <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_inc;
            r_wr_start   <= 1'b0;
            r_rd_start   <= 1'b0;
            r_burst_done <= 1'b0;
            r_rd_valid   <= (r_state == W_RD);

            case (r_state)
                W_IDLE: begin
                    if (init_done) begin
                        if (w_ref_pend) begin
                            r_state <= W_AR;
                            r_cnt   <= 10'd0;
                        end else if (wr_req) begin
                            r_state    <= W_ACTIVE;
                            r_cnt      <= 10'd0;
                            r_is_wr    <= 1'b1;
                            r_burst    <= clamp_burst(wr_burst);
                            r_wr_start <= 1'b1;
                        end else if (rd_req) begin
                            r_state    <= W_ACTIVE;
                            r_cnt      <= 10'd0;
                            r_is_wr    <= 1'b0;
                            r_burst    <= clamp_burst(rd_burst);
                            r_rd_start <= 1'b1;
                        end
                    end
                end
                W_ACTIVE: begin
                    r_cnt <= 10'd0;
                    if (TRCD > 1) begin
                        r_state <= W_TRCD;
                    end else begin
                        r_state <= r_is_wr ? W_WRITE : W_READ;
                    end
                end
                W_TRCD: begin
                    if (r_cnt == L_TRCD_END) begin
                        r_state <= r_is_wr ? W_WRITE : W_READ;
                        r_cnt   <= 10'd0;
                    end
                end
                W_WRITE: begin
                    r_cnt   <= 10'd0;
                    r_state <= (r_burst > 10'd1) ? W_WD : W_TWR;
                end
                W_WD: begin
                    if (r_cnt == (r_burst - 10'd2)) begin
                        r_state <= W_TWR;
                        r_cnt   <= 10'd0;
                    end
                end
                W_TWR: begin
                    if (r_cnt == L_TWR_END) begin
                        r_state <= L_AFTER_XFER;
                        r_cnt   <= 10'd0;
                    end
                end
                W_READ: begin
                    r_cnt   <= 10'd0;
                    r_state <= (TCL > 1) ? W_CL : W_RD;
                end
                W_CL: begin
                    if (r_cnt == L_CL_END) begin
                        r_state <= W_RD;
                        r_cnt   <= 10'd0;
                    end
                end
                W_RD: begin
                    if (r_cnt == (r_burst - 10'd1)) begin
                        r_state <= L_AFTER_XFER;
                        r_cnt   <= 10'd0;
                    end
                end
                W_PRE: begin
                    r_state <= W_TRP;
                    r_cnt   <= 10'd0;
                end
                W_TRP: begin
                    if (r_cnt == L_TRP_END) begin
                        r_state      <= W_IDLE;
                        r_cnt        <= 10'd0;
                        r_burst_done <= 1'b1;
                    end
                end
                W_AR: begin
                    r_state <= W_TRFC;
                    r_cnt   <= 10'd0;
                end
                W_TRFC: begin
                    if (r_cnt == L_TRFC_END) begin
                        r_state <= W_IDLE;
                        r_cnt   <= 10'd0;
                    end
                end
                default: begin
                    r_state <= W_IDLE;
                    r_cnt   <= 10'd0;
                end
            endcase
        end
    end

    assign work_state = r_state;
    assign cnt_clk    = r_cnt;
    assign wr_start   = r_wr_start;
    assign rd_start   = r_rd_start;
    // Upstream FIFO pops in the same cycle the DQ bus is driven.
    assign wr_ack     = (r_state == W_WRITE) || (r_state == W_WD);
    assign rd_valid   = r_rd_valid;
    assign burst_done = r_burst_done;

endmodule

// File: tb/tb_sdram_work_fsm.sv
// Directed bench for sdram_work_fsm: refresh, write, read, arbitration,
// burst clamping, counter saturation and asynchronous reset mid-burst.
module tb_sdram_work_fsm;
    import sdram_para::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       init_done;
    logic       wr_req;
    logic       rd_req;
    logic [9:0] wr_burst;
    logic [9:0] rd_burst;
    logic [3:0] work_state;
    logic [9:0] cnt_clk;
    logic       wr_start;
    logic       rd_start;
    logic       wr_ack;
    logic       rd_valid;
    logic       burst_done;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    int   n_st [16];
    int   n_ack, n_rv, n_lag, n_wrs, n_rds, n_bd_mid;
    logic bd_idle;
    logic timeout;
    logic found;

`ifdef SDRAM_AUTO_PRECHARGE_EN
    localparam int EXP_PRE = 0;
`else
    localparam int EXP_PRE = 1;
`endif

    always #5 clk = ~clk;

    sdram_work_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .init_done  (init_done),
        .wr_req     (wr_req),
        .rd_req     (rd_req),
        .wr_burst   (wr_burst),
        .rd_burst   (rd_burst),
        .work_state (work_state),
        .cnt_clk    (cnt_clk),
        .wr_start   (wr_start),
        .rd_start   (rd_start),
        .wr_ack     (wr_ack),
        .rd_valid   (rd_valid),
        .burst_done (burst_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Walk a non-idle sequence until W_IDLE, tallying states and handshakes.
    task automatic observe(input int max_cyc);
        logic [3:0] prev;
        for (int s = 0; s < 16; s++) n_st[s] = 0;
        n_ack = 0; n_rv = 0; n_lag = 0; n_wrs = 0; n_rds = 0; n_bd_mid = 0;
        bd_idle = 1'b0;
        timeout = 1'b1;
        prev = W_IDLE;
        for (int i = 0; i < max_cyc; i++) begin
            if (rd_valid !== (prev == W_RD)) n_lag++;
            if (rd_valid === 1'b1) n_rv++;
            if (work_state == W_IDLE) begin
                bd_idle = burst_done;
                timeout = 1'b0;
                break;
            end
            n_st[work_state]++;
            if (wr_ack === 1'b1)     n_ack++;
            if (burst_done === 1'b1) n_bd_mid++;
            if (wr_start === 1'b1)   n_wrs++;
            if (rd_start === 1'b1)   n_rds++;
            prev = work_state;
            tick();
        end
        check("observe_timeout", 32'(timeout), 32'd0);
    endtask

    initial begin
        rst = 1'b1; init_done = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        wr_burst = 10'd0; rd_burst = 10'd0;
        #1;
        check("rst_state",      32'(work_state), 32'(W_IDLE));
        check("rst_cnt",        32'(cnt_clk),    32'd0);
        check("rst_wr_start",   32'(wr_start),   32'd0);
        check("rst_rd_start",   32'(rd_start),   32'd0);
        check("rst_wr_ack",     32'(wr_ack),     32'd0);
        check("rst_rd_valid",   32'(rd_valid),   32'd0);
        check("rst_burst_done", 32'(burst_done), 32'd0);
        tick();
        rst = 1'b0;

        // init_done low: idle, counter runs and saturates
        repeat (3) tick();
        check("idle_cnt3", 32'(cnt_clk), 32'd3);
        wr_req = 1'b1;
        repeat (1027) tick();
        check("idle_no_init", 32'(work_state), 32'(W_IDLE));
        check("cnt_sat", 32'(cnt_clk), 32'd1023);
        wr_req = 1'b0;

        // Test 1: refresh at cycle 782 after init_done
        init_done = 1'b1;
        repeat (781) tick();
        check("t1_idle_781", 32'(work_state), 32'(W_IDLE));
        tick();
        check("t1_ar_782", 32'(work_state), 32'(W_AR));
        check("t1_ar_cnt", 32'(cnt_clk), 32'd0);
        observe(20);
        check("t1_n_ar",   32'(n_st[W_AR]),   32'd1);
        check("t1_n_trfc", 32'(n_st[W_TRFC]), 32'd7);
        check("t1_bd",     32'(bd_idle),      32'd0);
        check("t1_bd_mid", 32'(n_bd_mid),     32'd0);

        // Test 2: write burst of 4; later burst-length change is ignored
        wr_req = 1'b1; wr_burst = 10'd4;
        tick();
        check("t2_active", 32'(work_state), 32'(W_ACTIVE));
        check("t2_wr_start", 32'(wr_start), 32'd1);
        wr_req = 1'b0; wr_burst = 10'd9;
        observe(40);
        check("t2_n_trcd",  32'(n_st[W_TRCD]),  32'd1);
        check("t2_n_write", 32'(n_st[W_WRITE]), 32'd1);
        check("t2_n_wd",    32'(n_st[W_WD]),    32'd3);
        check("t2_n_twr",   32'(n_st[W_TWR]),   32'd2);
        check("t2_n_pre",   32'(n_st[W_PRE]),   32'(EXP_PRE));
        check("t2_n_trp",   32'(n_st[W_TRP]),   32'd2);
        check("t2_acks",    32'(n_ack),         32'd4);
        check("t2_wrs",     32'(n_wrs),         32'd1);
        check("t2_bd",      32'(bd_idle),       32'd1);
        tick();
        check("t2_bd_pulse", 32'(burst_done), 32'd0);

        // Test 3: read burst of 8
        rd_req = 1'b1; rd_burst = 10'd8;
        tick();
        check("t3_rd_start", 32'(rd_start), 32'd1);
        rd_req = 1'b0;
        observe(40);
        check("t3_n_read", 32'(n_st[W_READ]), 32'd1);
        check("t3_n_cl",   32'(n_st[W_CL]),   32'd2);
        check("t3_n_rd",   32'(n_st[W_RD]),   32'd8);
        check("t3_rv",     32'(n_rv),         32'd8);
        check("t3_lag",    32'(n_lag),        32'd0);
        check("t3_acks",   32'(n_ack),        32'd0);
        check("t3_bd",     32'(bd_idle),      32'd1);

        // Test 5: burst length clamping
        rd_req = 1'b1; rd_burst = 10'd0;
        tick();
        rd_req = 1'b0;
        observe(40);
        check("t5_rd0_n_rd", 32'(n_st[W_RD]), 32'd1);
        check("t5_rd0_rv",   32'(n_rv),       32'd1);
        rd_req = 1'b1; rd_burst = 10'd700;
        tick();
        rd_req = 1'b0;
        observe(600);
        check("t5_rd700_n_rd", 32'(n_st[W_RD]), 32'd512);
        check("t5_rd700_rv",   32'(n_rv),       32'd512);
        check("t5_rd700_lag",  32'(n_lag),      32'd0);

        // Test 4: refresh pending with simultaneous write and read requests
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (781) tick();
        wr_req = 1'b1; rd_req = 1'b1; wr_burst = 10'd2; rd_burst = 10'd3;
        tick();
        check("t4_ar_first", 32'(work_state), 32'(W_AR));
        check("t4_no_start", 32'(wr_start), 32'd0);
        observe(20);
        check("t4_n_trfc", 32'(n_st[W_TRFC]), 32'd7);
        tick();
        check("t4_wr_next", 32'(wr_start), 32'd1);
        check("t4_rd_held", 32'(rd_start), 32'd0);
        wr_req = 1'b0;
        observe(40);
        check("t4_wr_acks", 32'(n_ack),       32'd2);
        check("t4_wr_wd",   32'(n_st[W_WD]),  32'd1);
        check("t4_wr_rds",  32'(n_rds),       32'd0);
        tick();
        check("t4_rd_next", 32'(rd_start), 32'd1);
        rd_req = 1'b0;
        observe(40);
        check("t4_rd_rv", 32'(n_rv), 32'd3);
        check("t4_rd_bd", 32'(bd_idle), 32'd1);

        // Test 6: asynchronous reset mid-W_WD
        wr_req = 1'b1; wr_burst = 10'd10;
        tick();
        wr_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if ((work_state == W_WD) && (cnt_clk == 10'd5)) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("t6_reach_wd5", 32'(found), 32'd1);
        check("t6_ack_pre",   32'(wr_ack), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_state", 32'(work_state), 32'(W_IDLE));
        check("t6_ack",   32'(wr_ack),     32'd0);
        check("t6_cnt",   32'(cnt_clk),    32'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
